// File: rtl/pdm_demod_if.sv
// Bundles the PDM input strobe/bit and the decimated sample output of pdm_demod.
// The master drives tick/pdm and consumes samples; pdm_demod attaches as slave.
interface pdm_demod_if #(
    parameter int OUT_W = 8
);
    logic                    tick_in;
    logic                    pdm_in;
    logic signed [OUT_W-1:0] sample_out;
    logic                    sample_valid_out;

    modport master (
        output tick_in,
        output pdm_in,
        input  sample_out,
        input  sample_valid_out
    );

    modport slave (
        input  tick_in,
        input  pdm_in,
        output sample_out,
        output sample_valid_out
    );
endinterface

// File: rtl/pdm_demod.sv
// Boxcar PDM demodulator: counts ones over DECIM ticks and emits one signed sample per window.
// Optional PDM_DEMOD_AVG4_EN adds a 4-window moving average with one extra clock of latency.
module pdm_demod #(
    parameter int DECIM = 256,
    parameter int OUT_W = 8
) (
    input  logic        clk_in,
    input  logic        rst_in,
    pdm_demod_if.slave  bus
);
    localparam int CNT_W = $clog2(DECIM);
    localparam int RAW_W = CNT_W + 2;
    localparam int SHIFT = CNT_W + 1 - OUT_W;

    localparam logic [CNT_W-1:0]        LAST_TICK = CNT_W'(DECIM - 1);
    localparam logic signed [RAW_W-1:0] DECIM_V   = RAW_W'(DECIM);
    localparam logic signed [OUT_W-1:0] SAT_MAX   = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic signed [OUT_W-1:0] SAT_MIN   = {1'b1, {(OUT_W-1){1'b0}}};

    if ((DECIM < 2) || (DECIM > 4096) || ((1 << CNT_W) != DECIM) || (CNT_W < OUT_W - 1)) begin : g_param_check
        $error("pdm_demod: DECIM must be a power of two in 2..4096 with log2(DECIM) >= OUT_W-1");
    end

    // Floor-scale the ±DECIM raw value down to OUT_W+1 bits (range ±2^(OUT_W-1)).
    function automatic logic signed [OUT_W:0] scale_raw(input logic signed [RAW_W-1:0] raw);
        return (OUT_W+1)'(raw >>> SHIFT);
    endfunction

    function automatic logic signed [OUT_W-1:0] saturate(input logic signed [OUT_W:0] x);
        if (x[OUT_W] != x[OUT_W-1]) begin
            return x[OUT_W] ? SAT_MIN : SAT_MAX;
        end
        return x[OUT_W-1:0];
    endfunction

    // Stage p0: window counters and end-of-window sample computation
    logic [CNT_W-1:0]        tick_cnt_p0;
    logic [CNT_W:0]          ones_cnt_p0;
    logic [CNT_W:0]          ones_final_p0;
    logic signed [RAW_W-1:0] raw_p0;
    logic signed [OUT_W:0]   scaled_p0;
    logic                    win_end_p0;

    assign win_end_p0    = bus.tick_in && (tick_cnt_p0 == LAST_TICK);
    assign ones_final_p0 = ones_cnt_p0 + {{CNT_W{1'b0}}, bus.pdm_in};
    assign raw_p0        = $signed({ones_final_p0, 1'b0}) - DECIM_V;
    assign scaled_p0     = scale_raw(raw_p0);

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            tick_cnt_p0 <= '0;
            ones_cnt_p0 <= '0;
        end else if (bus.tick_in) begin
            if (win_end_p0) begin
                tick_cnt_p0 <= '0;
                ones_cnt_p0 <= '0;
            end else begin
                tick_cnt_p0 <= tick_cnt_p0 + CNT_W'(1);
                ones_cnt_p0 <= ones_final_p0;
            end
        end
    end

`ifdef PDM_DEMOD_AVG4_EN
    // Stage p1: history of unsaturated scaled values, newest in entry 0
    logic signed [OUT_W:0]   hist_p1 [4];
    logic                    vld_p1;
    logic signed [OUT_W+2:0] sum_p1;
    logic signed [OUT_W:0]   avg_p1;

    assign sum_p1 = (OUT_W+3)'(hist_p1[0]) + (OUT_W+3)'(hist_p1[1])
                  + (OUT_W+3)'(hist_p1[2]) + (OUT_W+3)'(hist_p1[3]);
    assign avg_p1 = (OUT_W+1)'(sum_p1 >>> 2);

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < 4; i++) begin
                hist_p1[i] <= '0;
            end
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= win_end_p0;
            if (win_end_p0) begin
                hist_p1[0] <= scaled_p0;
                for (int i = 1; i < 4; i++) begin
                    hist_p1[i] <= hist_p1[i-1];
                end
            end
        end
    end

    // Stage p2: averaged, saturated output
    logic signed [OUT_W-1:0] sample_p2;
    logic                    vld_p2;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            sample_p2 <= '0;
            vld_p2    <= 1'b0;
        end else begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                sample_p2 <= saturate(avg_p1);
            end
        end
    end

    assign bus.sample_out       = sample_p2;
    assign bus.sample_valid_out = vld_p2;
`else
    // Stage p1: saturated output, registered on the window-ending tick edge
    logic signed [OUT_W-1:0] sample_p1;
    logic                    vld_p1;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            sample_p1 <= '0;
            vld_p1    <= 1'b0;
        end else begin
            vld_p1 <= win_end_p0;
            if (win_end_p0) begin
                sample_p1 <= saturate(scaled_p0);
            end
        end
    end

    assign bus.sample_out       = sample_p1;
    assign bus.sample_valid_out = vld_p1;
`endif
endmodule
